// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bus field widths and the i2c_cmd_arbiter FSM encodings.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_DATA_W = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARB   = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_RETRY = 3'd4;
  localparam logic [2:0] ST_RESP  = 3'd5;

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational rotate-priority picker: first valid requester after i_last, wrapping.
module i2c_rr_pick #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         i_req_valid,
  input  logic [$clog2(NREQ)-1:0] i_last,
  output logic [NREQ-1:0]         o_grant,
  output logic [$clog2(NREQ)-1:0] o_grant_id,
  output logic                    o_valid
);

  localparam int unsigned IDXW = $clog2(NREQ);

  always_comb begin
    int unsigned idx;
    idx        = 0;
    o_grant    = '0;
    o_grant_id = '0;
    o_valid    = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(i_last) + k) % NREQ;
      if (!o_valid && i_req_valid[idx]) begin
        o_valid      = 1'b1;
        o_grant[idx] = 1'b1;
        o_grant_id   = IDXW'(idx);
      end
    end
  end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter and sequencer sharing one I2C master among NREQ requesters.
// Define I2C_ARB_RETRY_EN to reissue NACKed transactions up to MAX_RETRY times.
module i2c_cmd_arbiter
  import i2c_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned MAX_RETRY   = 2
) (
  input  logic                         i2c_clk,
  input  logic                         reset,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [I2C_ADDR_W*NREQ-1:0]   req_addr,
  input  logic [I2C_DATA_W*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]              req_ready,
  output logic [NREQ-1:0]              rsp_done,
  output logic                         rsp_err,
  output logic                         m_start,
  output logic [I2C_ADDR_W-1:0]        m_addr,
  output logic [I2C_DATA_W-1:0]        m_data,
  input  logic                         m_busy,
  input  logic                         m_done,
  input  logic                         m_nack,
  output logic [$clog2(NREQ)-1:0]      grant_id,
  output logic [2:0]                   state_out
);

  localparam int unsigned IDXW = $clog2(NREQ);
  localparam int unsigned TW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [2:0]            r_state, w_state_nxt;
  logic [NREQ-1:0]       r_ready, w_ready_nxt;
  logic [NREQ-1:0]       r_done, w_done_nxt;
  logic                  r_err, w_err_nxt;
  logic                  r_start, w_start_nxt;
  logic [I2C_ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [I2C_DATA_W-1:0] r_data, w_data_nxt;
  logic [IDXW-1:0]       r_grant, w_grant_nxt;
  logic [IDXW-1:0]       r_last, w_last_nxt;
  logic [TW-1:0]         r_tmo, w_tmo_nxt;

  logic [NREQ-1:0]       w_pick_oh;
  logic [IDXW-1:0]       w_pick_id;
  logic                  w_pick_valid;

`ifdef I2C_ARB_RETRY_EN
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] r_retry, w_retry_nxt;
`else
  logic w_unused_retry;
  assign w_unused_retry = (MAX_RETRY != 0);
`endif

  i2c_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .i_req_valid (req_valid),
    .i_last      (r_last),
    .o_grant     (w_pick_oh),
    .o_grant_id  (w_pick_id),
    .o_valid     (w_pick_valid)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_ready_nxt = '0;
    w_done_nxt  = '0;
    w_err_nxt   = 1'b0;
    w_start_nxt = 1'b0;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_tmo_nxt   = r_tmo;
`ifdef I2C_ARB_RETRY_EN
    w_retry_nxt = r_retry;
`endif
    case (r_state)
      ST_IDLE: begin
        if (|req_valid) w_state_nxt = ST_ARB;
      end
      ST_ARB: begin
        if (w_pick_valid) begin
          w_addr_nxt  = req_addr[w_pick_id*I2C_ADDR_W +: I2C_ADDR_W];
          w_data_nxt  = req_data[w_pick_id*I2C_DATA_W +: I2C_DATA_W];
          w_grant_nxt = w_pick_id;
          w_ready_nxt = w_pick_oh;
`ifdef I2C_ARB_RETRY_EN
          w_retry_nxt = '0;
`endif
          w_state_nxt = ST_START;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        if (!m_busy) begin
          w_start_nxt = 1'b1;
          w_tmo_nxt   = '0;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // m_done outranks a timeout landing on the same cycle.
        if (m_done) begin
          w_state_nxt = ST_RESP;
          w_done_nxt  = {{(NREQ-1){1'b0}}, 1'b1} << r_grant;
          w_err_nxt   = m_nack;
`ifdef I2C_ARB_RETRY_EN
          if (m_nack && (r_retry < RW'(MAX_RETRY))) begin
            w_state_nxt = ST_RETRY;
            w_done_nxt  = '0;
            w_err_nxt   = 1'b0;
          end
`endif
        end else if (r_tmo == TMO_LAST) begin
          w_state_nxt = ST_RESP;
          w_done_nxt  = {{(NREQ-1){1'b0}}, 1'b1} << r_grant;
          w_err_nxt   = 1'b1;
        end else begin
          w_tmo_nxt = r_tmo + TW'(1);
        end
      end
`ifdef I2C_ARB_RETRY_EN
      ST_RETRY: begin
        w_retry_nxt = r_retry + RW'(1);
        w_state_nxt = ST_START;
      end
`endif
      ST_RESP: begin
        w_last_nxt  = r_grant;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i2c_clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ready <= '0;
      r_done  <= '0;
      r_err   <= 1'b0;
      r_start <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_grant <= '0;
      r_last  <= IDXW'(NREQ - 1);
      r_tmo   <= '0;
`ifdef I2C_ARB_RETRY_EN
      r_retry <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_ready <= w_ready_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_start <= w_start_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_tmo   <= w_tmo_nxt;
`ifdef I2C_ARB_RETRY_EN
      r_retry <= w_retry_nxt;
`endif
    end
  end

  assign req_ready = r_ready;
  assign rsp_done  = r_done;
  assign rsp_err   = r_err;
  assign m_start   = r_start;
  assign m_addr    = r_addr;
  assign m_data    = r_data;
  assign grant_id  = r_grant;
  assign state_out = r_state;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Randomized bench for i2c_cmd_arbiter: cycle-timed reference built from the arbitration,
// launch, completion/timeout and retry rules, with a behavioural master model.
module tb_i2c_cmd_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned TMO  = 16;
  localparam int unsigned MAX_RETRY = 2;
`ifdef I2C_ARB_RETRY_EN
  localparam bit RetryOn = 1'b1;
`else
  localparam bit RetryOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [27:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_ready, rsp_done;
  logic        rsp_err, m_start, m_busy, m_done, m_nack;
  logic [6:0]  m_addr;
  logic [7:0]  m_data;
  logic [1:0]  grant_id;
  logic [2:0]  state_out;

  i2c_cmd_arbiter #(
    .NREQ        (NREQ),
    .TIMEOUT_CYC (TMO),
    .MAX_RETRY   (MAX_RETRY)
  ) dut (
    .i2c_clk   (clk),
    .reset     (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_done  (rsp_done),
    .rsp_err   (rsp_err),
    .m_start   (m_start),
    .m_addr    (m_addr),
    .m_data    (m_data),
    .m_busy    (m_busy),
    .m_done    (m_done),
    .m_nack    (m_nack),
    .grant_id  (grant_id),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Requester-side model state and the master's scripted replies per attempt.
  logic [3:0]  pend_valid;
  logic [6:0]  pend_addr [NREQ];
  logic [7:0]  pend_data [NREQ];
  int          model_last;
  int unsigned g_busy;
  int unsigned g_d [3];
  bit          g_nack [3];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] oh(input int i);
    return 4'(1 << i);
  endfunction

  function automatic int model_pick();
    for (int k = 1; k <= int'(NREQ); k++)
      if (pend_valid[(model_last + k) % NREQ]) return (model_last + k) % NREQ;
    return 0;
  endfunction

  task automatic drive_reqs();
    req_valid = pend_valid;
    for (int i = 0; i < int'(NREQ); i++) begin
      req_addr[i*7 +: 7] = pend_addr[i];
      req_data[i*8 +: 8] = pend_data[i];
    end
  endtask

  task automatic post(input int i);
    pend_valid[i] = 1'b1;
    pend_addr[i]  = 7'($urandom);
    pend_data[i]  = 8'($urandom);
  endtask

  task automatic set_resp(input int unsigned b, input int unsigned d0, input int unsigned d1,
                          input int unsigned d2, input bit n0, input bit n1, input bit n2);
    g_busy = b;
    g_d[0] = d0; g_d[1] = d1; g_d[2] = d2;
    g_nack[0] = n0; g_nack[1] = n1; g_nack[2] = n2;
  endtask

  // Entered with the DUT idle; runs one full request through grant, launch(es) and response.
  task automatic serve_one(output int w);
    int          att;
    int unsigned c;
    bit          fin, brk, exp_err;
    logic [6:0]  ea;
    logic [7:0]  ed;
    drive_reqs();
    w = model_pick();
    step();
    check_eq("arb_state", state_out, 3'd1);
    check_eq("arb_no_ready", req_ready, 4'd0);
    step();
    ea = pend_addr[w];
    ed = pend_data[w];
    check_eq("req_ready", req_ready, oh(w));
    check_eq("grant_id", grant_id, w);
    check_eq("m_addr_latch", m_addr, ea);
    check_eq("m_data_latch", m_data, ed);
    check_eq("start_state", state_out, 3'd2);
    pend_valid[w] = 1'b0;
    drive_reqs();
    att = 0; fin = 1'b0; exp_err = 1'b0;
    while (!fin) begin
      for (int k = 0; k < int'(g_busy); k++) begin
        m_busy = 1'b1;
        step();
        check_eq("busy_hold", {m_start, state_out}, {1'b0, 3'd2});
      end
      m_busy = 1'b0;
      step();
      check_eq("m_start", m_start, 1'b1);
      check_eq("wait_state", state_out, 3'd3);
      check_eq("m_bus_at_start", {m_addr, m_data}, {ea, ed});
      c = 0; brk = 1'b0;
      while (!brk) begin
        m_done = (c + 1 == g_d[att]);
        m_nack = m_done ? g_nack[att] : 1'($urandom);
        step();
        c++;
        if (c == g_d[att] || c == TMO) brk = 1'b1;
        else check_eq("wait_quiet", {m_start, rsp_done, state_out}, {1'b0, 4'd0, 3'd3});
      end
      m_done = 1'b0;
      m_nack = 1'b0;
      if (c == g_d[att] && !g_nack[att]) begin
        fin = 1'b1; exp_err = 1'b0;
      end else if (c == g_d[att] && RetryOn && att < int'(MAX_RETRY)) begin
        check_eq("retry_state", {rsp_done, m_start, state_out}, {4'd0, 1'b0, 3'd4});
        att++;
        step();
        check_eq("restart_state", {m_start, state_out}, {1'b0, 3'd2});
      end else begin
        fin = 1'b1; exp_err = 1'b1;
      end
    end
    check_eq("rsp_done", rsp_done, oh(w));
    check_eq("rsp_err", rsp_err, exp_err);
    check_eq("resp_state", {m_start, state_out}, {1'b0, 3'd5});
    check_eq("m_bus_at_done", {m_addr, m_data}, {ea, ed});
    model_last = w;
    step();
    check_eq("back_to_idle", {rsp_done, rsp_err, state_out}, 8'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1;
    req_valid = '0; req_addr = '0; req_data = '0;
    m_busy = 1'b0; m_done = 1'b0; m_nack = 1'b0;
    pend_valid = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      pend_addr[i] = '0;
      pend_data[i] = '0;
    end
    model_last = NREQ - 1;
    set_resp(0, 4, 4, 4, 0, 0, 0);
    repeat (3) step();
    check_eq("reset_outputs",
             {req_ready, rsp_done, rsp_err, m_start, m_addr, m_data, grant_id, state_out}, 0);
    rst = 1'b0;
    step();
    check_eq("idle_after_reset", {state_out, grant_id}, 0);

    // All four post continuously; each re-posts once served.
    for (int i = 0; i < int'(NREQ); i++) post(i);
    for (int n = 0; n < 5; n++) begin
      set_resp($urandom % 2, 3 + $urandom % 6, 4, 4, 0, 0, 0);
      serve_one(w);
      post(w);
    end
    pend_valid = '0;
    drive_reqs();
    step();
    check_eq("withdrawn_idle", {req_ready, state_out}, 0);

    // Single request from requester 0 with fixed fields.
    pend_valid = 4'b0001;
    pend_addr[0] = 7'b1101001;
    pend_data[0] = 8'b10101010;
    set_resp(0, 14, 0, 0, 0, 0, 0);
    serve_one(w);

    // NACK handling: NACK,NACK,ACK then three NACKs.
    post(1); set_resp(0, 5, 6, 7, 1, 1, 0); serve_one(w);
    post(2); set_resp(1, 3, 9, 2, 1, 1, 1); serve_one(w);

    // Timeout with no m_done, then m_done (ACK) on the final count.
    post(3); set_resp(0, 0, 0, 0, 0, 0, 0); serve_one(w);
    post(0); set_resp(0, TMO, 0, 0, 0, 0, 0); serve_one(w);

    // Master busy for 10 cycles on START entry.
    post(1); set_resp(10, 6, 6, 6, 0, 0, 0); serve_one(w);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < int'(NREQ); i++)
        if (!pend_valid[i] && ($urandom % 2 == 1)) post(i);
      if (pend_valid == 4'd0) post($urandom % NREQ);
      g_busy = $urandom % 3;
      for (int a = 0; a < 3; a++) begin
        g_d[a]    = ($urandom % 6 == 0) ? 0 : 1 + ($urandom % TMO);
        g_nack[a] = ($urandom % 3 == 0);
      end
      serve_one(w);
    end

    // Reset while in WAIT.
    pend_valid = '0;
    post(1);
    drive_reqs();
    step();
    step();
    pend_valid = '0;
    drive_reqs();
    m_busy = 1'b0;
    step();
    check_eq("pre_reset_start", m_start, 1'b1);
    repeat (3) step();
    check_eq("pre_reset_wait", state_out, 3'd3);
    #2 rst = 1'b1;
    #1;
    check_eq("async_reset_outputs",
             {req_ready, rsp_done, rsp_err, m_start, m_addr, m_data, grant_id, state_out}, 0);
    step();
    step();
    check_eq("reset_no_done", {rsp_done, state_out}, 0);
    rst = 1'b0;
    model_last = NREQ - 1;
    post(0);
    post(2);
    set_resp(0, 5, 5, 5, 0, 0, 0);
    serve_one(w);
    serve_one(w);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
